// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Signal bundle between the writeback stage, the long-latency
//               unit (LLU), decode hazard logic and the register-file write
//               port, as seen by wb_port_arbiter.
//   slave  modport : the arbiter side (pipeline/LLU/decode in, RF/status out)
//   master modport : the surrounding pipeline side (mirror of slave)
//   Pipeline WB : RegWriteW, RdW[4:0], ResultW[31:0]
//   LLU result  : llu_valid, llu_rd[4:0], llu_data[31:0], llu_ready
//   Decode      : llu_issue, llu_issue_rd[4:0], Rs1D/Rs2D[4:0],
//                 rs1_busy, rs2_busy
//   RF port     : rf_we, rf_rd[4:0], rf_wd[31:0]
//   Starvation  : bubble_req
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        llu_issue;
  logic [4:0]  llu_issue_rd;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        bubble_req;

  modport slave (
    input  RegWriteW, RdW, ResultW,
    input  llu_valid, llu_rd, llu_data,
    output llu_ready,
    input  llu_issue, llu_issue_rd, Rs1D, Rs2D,
    output rs1_busy, rs2_busy,
    output rf_we, rf_rd, rf_wd,
    output bubble_req
  );

  modport master (
    output RegWriteW, RdW, ResultW,
    output llu_valid, llu_rd, llu_data,
    input  llu_ready,
    output llu_issue, llu_issue_rd, Rs1D, Rs2D,
    input  rs1_busy, rs2_busy,
    input  rf_we, rf_rd, rf_wd,
    input  bubble_req
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               pipeline writeback stage and a long-latency unit. LLU results
//               are queued in a small FIFO and written in slots the pipeline
//               leaves free; a per-register scoreboard flags pending LLU
//               destinations to decode.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               bus (slave)  - wb_port_arbiter_if bundle (see interface)
// Parameters  : DEPTH        - LLU FIFO entries (power of two, >= 2)
//               STARVE_LIMIT - head-wait cycles before bubble_req (1..255)
// Options     : WB_ARB_STARVE_EN - enables the starvation guard (wait
//               counter + bubble_req); otherwise bubble_req is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  wb_port_arbiter_if.slave bus
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [4:0]       r_rd_mem   [DEPTH];
  logic [31:0]      r_data_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;
  logic [31:0]      w_busy_next;

  logic        w_empty;
  logic        w_full;
  logic        w_claim;
  logic        w_grant;
  logic        w_push;
  logic [4:0]  w_head_rd;
  logic [31:0] w_head_data;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_FULL);
  assign w_claim     = bus.RegWriteW && (bus.RdW != 5'd0);
  // Head is only visible once registered, so a push is never granted in
  // the cycle it arrives.
  assign w_grant     = !w_claim && !w_empty;
  // x0 results complete the handshake but are discarded.
  assign w_push      = bus.llu_valid && !w_full && (bus.llu_rd != 5'd0);
  assign w_head_rd   = r_rd_mem[r_rd_ptr];
  assign w_head_data = r_data_mem[r_rd_ptr];

  assign bus.llu_ready = !w_full;
  assign bus.rs1_busy  = r_busy[bus.Rs1D];
  assign bus.rs2_busy  = r_busy[bus.Rs2D];

  // Write-port mux: pipeline first, then FIFO head, else idle.
  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_rd = 5'd0;
    bus.rf_wd = 32'd0;
    if (!rst) begin
      if (w_claim) begin
        bus.rf_we = 1'b1;
        bus.rf_rd = bus.RdW;
        bus.rf_wd = bus.ResultW;
      end else if (w_grant) begin
        bus.rf_we = 1'b1;
        bus.rf_rd = w_head_rd;
        bus.rf_wd = w_head_data;
      end
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr]   <= bus.llu_rd;
      r_data_mem[r_wr_ptr] <= bus.llu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_grant) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_grant})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Scoreboard: clear on grant first so a same-cycle issue re-sets the bit.
  always_comb begin
    w_busy_next = r_busy;
    if (w_grant) w_busy_next[w_head_rd] = 1'b0;
    if (bus.llu_issue && (bus.llu_issue_rd != 5'd0)) w_busy_next[bus.llu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= {w_busy_next[31:1], 1'b0};
  end

`ifdef WB_ARB_STARVE_EN
  localparam logic [7:0] C_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_next;
  logic       r_bubble;

  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_empty || w_grant)      w_wait_next = 8'd0;
    else if (r_wait_cnt != 8'hFF) w_wait_next = r_wait_cnt + 8'd1;
  end

  // Flag rises on the edge where the counter reaches the limit and drops
  // on the edge that pops the starved head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_bubble   <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_next;
      if (w_grant)                     r_bubble <= 1'b0;
      else if (w_wait_next >= C_LIMIT) r_bubble <= 1'b1;
    end
  end

  assign bus.bubble_req = r_bubble;
`else
  wire [7:0] w_unused_limit = 8'(STARVE_LIMIT);
  assign bus.bubble_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency unit (LLU, e.g. divider or multi-cycle multiplier). LLU results are buffered in a small FIFO and drained into write-port slots the pipeline leaves unused. A per-register scoreboard exposes pending LLU destinations to the decode-stage hazard logic. An optional starvation guard requests a pipeline bubble when LLU results wait too long. Sits between writeback_cycle's ResultW mux and the register file.

## Interface
- DEPTH, 2 — LLU result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8 — head-wait cycles before bubble_req; 1..255

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- RegWriteW  in  1  pipeline writeback enable
- RdW  in  5  pipeline destination register
- ResultW  in  32  pipeline writeback data
- llu_valid  in  1  LLU result valid
- llu_rd  in  5  LLU result destination
- llu_data  in  32  LLU result data
- llu_ready  out  1  FIFO can accept; equals !full
- llu_issue  in  1  LLU op issued this cycle (from decode)
- llu_issue_rd  in  5  destination of issued LLU op
- Rs1D, Rs2D  in  5 each  decode-stage source registers
- rs1_busy, rs2_busy  out  1 each  source has pending LLU write
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wd  out  32  register-file write data
- bubble_req  out  1  request pipeline to free one writeback slot

## Operation
- Pipeline claim: RegWriteW && RdW != 0. Claim always wins; rf_we=1, rf_rd=RdW, rf_wd=ResultW.
- Otherwise, FIFO non-empty: head granted; rf_we=1, rf_rd/rf_wd from head; pop same edge.
- Otherwise rf_we=0, rf_rd=0, rf_wd=0. Pipeline writes to x0 never reach rf_we and leave the slot to the LLU.
- FIFO push on llu_valid && llu_ready. llu_rd==0 results are accepted and dropped (not stored). No fall-through: a pushed entry is grantable the cycle after the push at the earliest. Push and pop in the same cycle are legal when not full. Pointers wrap modulo DEPTH, and the count is DEPTH+1 values wide.
- Scoreboard: busy[31:1] flops, busy[0] hardwired 0. Set on llu_issue for llu_issue_rd != 0. Cleared when an LLU entry for that rd is granted. Set and clear on the same rd in the same cycle: set wins.
- rsN_busy = busy[RsN] from the registered state. There is no same-cycle bypass of a grant.
- Pipeline writes to a busy rd do not change the scoreboard. The later LLU write overwrites that register; preventing this is the hazard unit's job.

## Timing
- rf_we/rf_rd/rf_wd are combinational from the current inputs and the FIFO head, giving zero added latency to the pipeline path. rf_we is forced to 0 while rst=1.
- LLU latency from push to write is at least 1 cycle, unbounded under continuous pipeline claims unless guarded.
- llu_ready is a registered-state function, so it does not depend on llu_valid.
- Reset values: FIFO empty, llu_ready=1, busy all 0, rs1_busy=rs2_busy=0, wait counter 0, bubble_req=0, rf_we=0.
- Reset mid-operation discards all FIFO entries and busy bits immediately (async). No pending write survives.

## Configuration
- WB_ARB_STARVE_EN defined:
  - 8-bit wait_cnt increments each cycle the FIFO is non-empty and the head is not granted. It saturates at 255.
  - wait_cnt clears on any pop or when the FIFO is empty.
  - bubble_req is a registered flag, set when wait_cnt reaches STARVE_LIMIT. It holds until the cycle after the head is granted.
  - The pipeline contract is to deliver a non-claiming writeback cycle while bubble_req=1.
- Not defined: no counter, bubble_req tied 0, strict pipeline priority.

## Test plan
- Reset, then llu_issue with rd=5 → rs1_busy=1 for Rs1D=5 next cycle; rf_we=0; llu_ready=1.
- LLU push rd=5 data 0xDEAD with RegWriteW=0 → next cycle rf_we=1, rf_rd=5, rf_wd=0xDEAD; busy[5] clears the following cycle.
- RegWriteW=1, RdW=3, ResultW=0x4 held while the LLU pushes rd=7 twice → rf_rd=3 every cycle; llu_ready=0 after 2 pushes. Drop RegWriteW → rd=7 entries drain over 2 consecutive cycles in FIFO order.
- RegWriteW=1 with RdW=0 and FIFO holding rd=9 → rf_we=1, rf_rd=9 (x0 slot reused).
- With WB_ARB_STARVE_EN and STARVE_LIMIT=8, pipeline claims continuously with 1 FIFO entry → bubble_req=1 after 8 waiting cycles. Releasing one slot grants the head, and bubble_req=0 the next cycle.
- Same-cycle llu_issue rd=4 and grant of pending rd=4 → busy[4] stays 1. Assert rst mid-drain → FIFO empty, all busy 0, rf_we=0 immediately.
